clock_ratio_meter: RTL and testbench



---
 rtl/clock_div_pkg.sv | 25 ++
 rtl/clock_ratio_meter_edge_sync.sv | 42 ++++
 rtl/clock_ratio_meter.sv | 156 +++++++++++++++
 tb/tb_clock_ratio_meter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// -----------------------------------------------------------------------------
// clock_div_pkg
// Definitions shared by the clock divider and the clock ratio meter.
//   DEF_CNT_W      default width of period/high-time counters
//   meter_state_e  meter state encoding (DISARMED=0, ARMED=1)
//   sat_value()    all-ones saturation constant for a counter of width w
// -----------------------------------------------------------------------------
package clock_div_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } meter_state_e;

  // Largest value a w-bit counter can hold (2^w - 1), clamped to 32 bits.
  function automatic logic [31:0] sat_value(input int w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/clock_ratio_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Two-flop synchronizer (s1, s2) for an asynchronous input plus a delay flop
// (s3) used for edge detection. All flops clear on synchronous reset.
// Ports:
//   clk    in   sampling clock
//   rst    in   synchronous active-high reset
//   sig_in in   asynchronous input
//   level  out  synchronized level (s2)
//   rise   out  s2 & ~s3, one cycle per synchronized rising edge
//   fall   out  ~s2 & s3, one cycle per synchronized falling edge
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/clock_ratio_meter.sv
// -----------------------------------------------------------------------------
// clock_ratio_meter
// Counts clk_in cycles between consecutive rising edges of sig_in and reports
// the rise-to-rise period and the high time within it. Flags a missing input
// (no rise within 2^CNT_W-1 cycles) and, optionally, frequency lock.
//
// Build option: define CLOCK_RATIO_METER_LOCK_DETECT_EN to build the lock
// detector; without it `locked` is tied low and LOCK_CNT has no effect.
//
// Parameters:
//   CNT_W     width of counters and of period/high_time (<= 32)
//   LOCK_CNT  consecutive identical periods needed for `locked` (1..15)
// Ports:
//   clk_in     in   reference clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   sig_in     in   measured signal, asynchronous to clk_in
//   period     out  last measured rise-to-rise period in clk_in cycles
//   high_time  out  clk_in cycles sig_in was high within that period
//   meas_valid out  one-cycle pulse when period/high_time update
//   no_clk     out  level, no rising edge within 2^CNT_W-1 cycles
//   locked     out  level, last LOCK_CNT periods were identical
//   state_dbg  out  current meter state, for observation only
//
// meas_valid has no ready counterpart: it is a pure strobe, high for exactly
// the one cycle in which period/high_time take a new value; the values hold
// until the next strobe, a timeout (hold) or reset (clear).
// -----------------------------------------------------------------------------
module clock_ratio_meter
  import clock_div_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             no_clk,
  output logic             locked,
  output meter_state_e     state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_value(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic         level;
  logic         rise;
  logic         fall;
  meter_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic         h_frozen;  // a fall has been seen since the last rise

  edge_sync u_edge_sync (
    .clk    (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // A rise always takes priority over the timeout, so a period of exactly
  // CNT_MAX is still reported; the timeout only fires when cnt sits at
  // CNT_MAX without a rise, which also keeps cnt from ever wrapping.
  wire timeout = (state == ARMED) && !rise && (cnt == CNT_MAX);
  wire measure = (state == ARMED) && rise;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= DISARMED;
      cnt        <= '0;
      hcnt       <= '0;
      h_frozen   <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      no_clk     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        DISARMED: begin
          // The first rise only starts a measurement window.
          if (rise) begin
            cnt      <= CNT_ONE;
            hcnt     <= CNT_ONE;
            h_frozen <= 1'b0;
            no_clk   <= 1'b0;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (measure) begin
            period     <= cnt;
            high_time  <= hcnt;
            meas_valid <= 1'b1;
            cnt        <= CNT_ONE;
            hcnt       <= CNT_ONE;
            h_frozen   <= 1'b0;
          end else if (timeout) begin
            no_clk <= 1'b1;
            state  <= DISARMED;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (fall) begin
              h_frozen <= 1'b1;
            end else if (level && !h_frozen) begin
              hcnt <= hcnt + CNT_ONE;
            end
          end
        end
        default: state <= DISARMED;
      endcase
    end
  end

  assign state_dbg = state;

`ifdef CLOCK_RATIO_METER_LOCK_DETECT_EN
  // match counts consecutive equal periods since arming; 0 means no
  // measurement yet, so the first one after arming always restarts at 1.
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

  logic [3:0] match;
  logic [3:0] match_next;

  always_comb begin
    match_next = 4'd1;
    if ((match != 4'd0) && (cnt == period)) begin
      match_next = (match == LOCK_TARGET) ? match : match + 4'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      match  <= 4'd0;
      locked <= 1'b0;
    end else if (measure) begin
      match  <= match_next;
      locked <= (match_next == LOCK_TARGET);
    end else if (timeout) begin
      match  <= 4'd0;
      locked <= 1'b0;
    end
  end
`else
  // Without lock detection LOCK_CNT only appears in this range guard.
  if ((LOCK_CNT < 1) || (LOCK_CNT > 15)) begin : g_lock_cnt_out_of_range
  end

  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ratio_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_ratio_meter
// Drives clock_ratio_meter (CNT_W=8, LOCK_CNT=4) with directed and random
// square waves. The reference keeps rise/fall timestamps of the sampled input
// and derives period, high time, timeout and lock from them.
// -----------------------------------------------------------------------------
module tb_clock_ratio_meter;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef CLOCK_RATIO_METER_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic sig_in;

  always #5 clk = ~clk;

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             no_clk;
  logic             locked;
  logic             state_dbg;

  clock_ratio_meter #(
    .CNT_W    (CNT_W),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk_in     (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .no_clk     (no_clk),
    .locked     (locked),
    .state_dbg  (state_dbg)
  );

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endfunction

  // ---------------- reference model ----------------
  // The meter acts at edge t on the input sampled at edge t-2. Samples taken
  // while reset is asserted count as 0.
  int  t = 0;
  bit  smp1, smp2, smp3;   // samples from edges t-1, t-2, t-3
  bit  armed;
  int  last_rise;
  int  first_fall;
  int  exp_period, exp_high;
  bit  exp_mv, exp_noclk, exp_locked;
  logic [CNT_W-1:0] exp_q[$];   // periods measured since arming, newest last

  function automatic bit all_equal_full();
    if (exp_q.size() != LOCK_CNT) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i] != exp_q[0]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit cur, prv, r, f;
    t++;
    if (rst) begin
      smp1 = 0; smp2 = 0; smp3 = 0;
      armed = 0;
      exp_period = 0; exp_high = 0; exp_mv = 0; exp_noclk = 0; exp_locked = 0;
      exp_q.delete();
    end else begin
      cur = smp2;
      prv = smp3;
      r = cur & ~prv;
      f = ~cur & prv;
      smp3 = smp2; smp2 = smp1; smp1 = sig_in;
      exp_mv = 0;
      if (!armed) begin
        if (r) begin
          armed = 1; exp_noclk = 0; last_rise = t; first_fall = -1;
          exp_q.delete();
        end
      end else if (r) begin
        exp_period = t - last_rise;
        exp_high   = first_fall - last_rise;
        exp_mv     = 1;
        exp_q.push_back(CNT_W'(exp_period));
        if (exp_q.size() > LOCK_CNT) void'(exp_q.pop_front());
        last_rise  = t;
        first_fall = -1;
      end else if (t - last_rise == CNT_MAX) begin
        exp_noclk = 1;
        armed = 0;
        exp_q.delete();
      end else if (f && first_fall < 0) begin
        first_fall = t;
      end
      exp_locked = LOCK_EN && all_equal_full();
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (checking) begin
      check("period",     32'(period),     32'(exp_period));
      check("high_time",  32'(high_time),  32'(exp_high));
      check("meas_valid", 32'(meas_valid), 32'(exp_mv));
      check("no_clk",     32'(no_clk),     32'(exp_noclk));
      check("locked",     32'(locked),     32'(exp_locked));
      check("state",      32'(state_dbg),  32'(armed));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v);
    @(negedge clk);
    sig_in = v;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) step(i < h);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lit(input int p, input int h, input bit nc, input bit lk,
                     input string tag);
    check({tag, "_period"},    32'(period),    32'(p));
    check({tag, "_high_time"}, 32'(high_time), 32'(h));
    check({tag, "_no_clk"},    32'(no_clk),    32'(nc));
    check({tag, "_locked"},    32'(locked),    32'(lk));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p, h, n, kind;
    rst    = 1'b1;
    sig_in = 1'b0;
    @(negedge clk);
    checking = 1'b1;

    // Reset held while the input toggles.
    for (int i = 0; i < 6; i++) step(i[0]);
    lit(0, 0, 0, 0, "reset");
    check("reset_meas_valid", 32'(meas_valid), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    sig_in = 1'b0;
    hold(0, 3);

    wave(6, 3, 10);
    lit(6, 3, 0, LOCK_EN, "sq6");
    wave(12, 5, 6);
    lit(12, 5, 0, LOCK_EN, "sq12");
    wave(6, 3, 6);
    lit(6, 3, 0, LOCK_EN, "back6");

    // Input stops: timeout, then the next rise only re-arms.
    hold(0, 300);
    lit(6, 3, 1, 0, "timeout");
    wave(7, 1, 5);
    lit(7, 1, 0, LOCK_EN, "p7h1");
    wave(2, 1, 12);
    lit(2, 1, 0, LOCK_EN, "p2h1");

    // Period of exactly 2^CNT_W-1 is still measured.
    wave(CNT_MAX, 100, 3);
    lit(CNT_MAX, 100, 0, 0, "pmax");
    wave(CNT_MAX + 1, 50, 2);
    hold(0, 10);

    // Reset in the middle of a period.
    wave(6, 3, 3);
    hold(1, 2);
    pulse_reset();
    lit(0, 0, 0, 0, "midrst");
    check("midrst_meas_valid", 32'(meas_valid), 32'd0);
    hold(1, 1);
    hold(0, 3);
    wave(6, 3, 3);

    // Random segments.
    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        pulse_reset();
      end else if (kind == 1) begin
        hold(0, $urandom_range(200, 300));
      end else begin
        p = $urandom_range(2, 30);
        h = $urandom_range(1, p - 1);
        n = $urandom_range(1, 6);
        wave(p, h, n);
      end
    end

    hold(0, 5);
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
